// File: rtl/hazard_sequencer.sv
// Pipeline hazard control: load-use bubbles, branch flushes, operand forwarding
// and a stall sequencer for the multi-cycle mul/div unit with timeout abort.
module hazard_sequencer #(
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  readRegister1_D,
  input  logic [4:0]  readRegister2_D,
  input  logic [4:0]  readRegister1_E,
  input  logic [4:0]  readRegister2_E,
  input  logic [4:0]  writeReg_E,
  input  logic        memRead_E,
  input  logic        regWrite_M,
  input  logic        regWrite_W,
  input  logic [4:0]  writeReg_M,
  input  logic [4:0]  writeReg_W,
  input  logic        pcSrc_E,
  input  logic        mdStart_E,
  input  logic        mdDone,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        flush_D,
  output logic        flush_E,
  output logic        flush_M,
  output logic [1:0]  forwardA_E,
  output logic [1:0]  forwardB_E,
  output logic        md_busy,
  output logic        md_error,
  output logic [31:0] stallCycles
);

  localparam int unsigned CW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          md_error_nxt;
  logic          md_stall;
  logic          load_use;

  // State register, wait counter, sticky error and saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      md_error    <= 1'b0;
      stallCycles <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      md_error <= md_error_nxt;
      if (stall_F && (stallCycles != 32'hFFFF_FFFF))
        stallCycles <= stallCycles + 32'd1;
    end
  end

  // Mul/div sequencing; a start that completes in the same cycle never stalls
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    md_error_nxt = md_error;
    md_stall     = 1'b0;
    case (state)
      RUN: begin
        if (mdStart_E && !mdDone) begin
          md_stall     = 1'b1;
          state_nxt    = MD_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      MD_WAIT: begin
        if (mdDone) begin
          state_nxt = RUN;
        end else if (wait_cnt == CW'(MD_TIMEOUT - 1)) begin
          state_nxt    = RUN;
          md_error_nxt = 1'b1;
        end else begin
          md_stall     = 1'b1;
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign load_use = memRead_E && (writeReg_E != 5'd0) &&
                    ((writeReg_E == readRegister1_D) || (writeReg_E == readRegister2_D));

  // Stall/flush priority: mul/div wait, then branch redirect, then load-use bubble
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_M = 1'b0;
    if (!reset) begin
      if (md_stall) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        flush_M = 1'b1;
      end else if (pcSrc_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  // Forwarding muxes, MEM result is newer than WB so it wins
  always_comb begin
    forwardA_E = 2'b00;
    forwardB_E = 2'b00;
    if (!reset) begin
      if (regWrite_M && (writeReg_M != 5'd0) && (writeReg_M == readRegister1_E))
        forwardA_E = 2'b10;
      else if (regWrite_W && (writeReg_W != 5'd0) && (writeReg_W == readRegister1_E))
        forwardA_E = 2'b01;
      if (regWrite_M && (writeReg_M != 5'd0) && (writeReg_M == readRegister2_E))
        forwardB_E = 2'b10;
      else if (regWrite_W && (writeReg_W != 5'd0) && (writeReg_W == readRegister2_E))
        forwardB_E = 2'b01;
    end
  end

  assign md_busy = (state == MD_WAIT);

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: driver queues hand-computed per-cycle
// expectations, an independent monitor compares them mid-cycle.
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  readRegister1_D, readRegister2_D, readRegister1_E, readRegister2_E;
  logic [4:0]  writeReg_E, writeReg_M, writeReg_W;
  logic        memRead_E, regWrite_M, regWrite_W, pcSrc_E, mdStart_E, mdDone;
  logic        stall_F, stall_D, stall_E, flush_D, flush_E, flush_M;
  logic [1:0]  forwardA_E, forwardB_E;
  logic        md_busy, md_error;
  logic [31:0] stallCycles;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [11:0] flags;
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q[$];

  hazard_sequencer #(.MD_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .readRegister1_D(readRegister1_D), .readRegister2_D(readRegister2_D),
    .readRegister1_E(readRegister1_E), .readRegister2_E(readRegister2_E),
    .writeReg_E(writeReg_E), .memRead_E(memRead_E),
    .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
    .writeReg_M(writeReg_M), .writeReg_W(writeReg_W),
    .pcSrc_E(pcSrc_E), .mdStart_E(mdStart_E), .mdDone(mdDone),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
    .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .md_busy(md_busy), .md_error(md_error), .stallCycles(stallCycles)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, sampled on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [11:0] act;
      e   = exp_q.pop_front();
      act = {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M,
             forwardA_E, forwardB_E, md_busy, md_error};
      checks++;
      if (act !== e.flags) begin
        errors++;
        $display("FAIL %s flags: got %b expected %b (sF sD sE fD fE fM fwA fwB busy err)",
                 e.name, act, e.flags);
      end
      checks++;
      if (stallCycles !== e.sc) begin
        errors++;
        $display("FAIL %s stallCycles: got %0d expected %0d", e.name, stallCycles, e.sc);
      end
    end
  end

  task automatic clear_inputs();
    readRegister1_D = '0; readRegister2_D = '0;
    readRegister1_E = '0; readRegister2_E = '0;
    writeReg_E = '0; writeReg_M = '0; writeReg_W = '0;
    memRead_E = 1'b0; regWrite_M = 1'b0; regWrite_W = 1'b0;
    pcSrc_E = 1'b0; mdStart_E = 1'b0; mdDone = 1'b0;
  endtask

  // st={stall_F,stall_D,stall_E}, fl={flush_D,flush_E,flush_M}
  task automatic cyc(input string nm, input logic [2:0] st, input logic [2:0] fl,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic busy, input logic err, input logic [31:0] sc);
    exp_t e;
    e.name  = nm;
    e.flags = {st, fl, fa, fb, busy, err};
    e.sc    = sc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset masks hazards and forwarding
    memRead_E = 1'b1; writeReg_E = 5'd5; readRegister2_D = 5'd5; pcSrc_E = 1'b1;
    regWrite_M = 1'b1; writeReg_M = 5'd7; readRegister1_E = 5'd7;
    cyc("reset_mask", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0);

    reset = 1'b0; clear_inputs();
    cyc("idle", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0);

    memRead_E = 1'b1; writeReg_E = 5'd5; readRegister2_D = 5'd5;
    cyc("load_use", 3'b110, 3'b010, 2'b00, 2'b00, 0, 0, 0);
    clear_inputs();
    cyc("after_load_use", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 1);

    memRead_E = 1'b1; writeReg_E = 5'd0;
    cyc("load_x0", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 1);

    writeReg_E = 5'd5; readRegister2_D = 5'd5; pcSrc_E = 1'b1;
    cyc("branch_beats_load", 3'b000, 3'b110, 2'b00, 2'b00, 0, 0, 1);
    clear_inputs();

    regWrite_M = 1'b1; regWrite_W = 1'b1; writeReg_M = 5'd7; writeReg_W = 5'd7;
    readRegister1_E = 5'd7; readRegister2_E = 5'd7;
    cyc("fwd_mem_prio", 3'b000, 3'b000, 2'b10, 2'b10, 0, 0, 1);
    writeReg_M = 5'd0;
    cyc("fwd_wb", 3'b000, 3'b000, 2'b01, 2'b01, 0, 0, 1);
    writeReg_M = 5'd3; readRegister2_E = 5'd3;
    cyc("fwd_mixed", 3'b000, 3'b000, 2'b01, 2'b10, 0, 0, 1);
    writeReg_M = 5'd0; writeReg_W = 5'd0; readRegister1_E = 5'd0; readRegister2_E = 5'd0;
    cyc("fwd_regs0", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 1);
    regWrite_M = 1'b0; regWrite_W = 1'b0; writeReg_M = 5'd9; readRegister1_E = 5'd9;
    cyc("fwd_nowrite", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 1);
    clear_inputs();

    reset = 1'b1;
    cyc("reset_pre_md", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 1);
    reset = 1'b0;

    // Mul/div: start (with a competing branch), four waits, done
    mdStart_E = 1'b1; pcSrc_E = 1'b1;
    cyc("md_start", 3'b111, 3'b001, 2'b00, 2'b00, 0, 0, 0);
    clear_inputs();
    for (int i = 0; i < 4; i++)
      cyc("md_wait", 3'b111, 3'b001, 2'b00, 2'b00, 1, 0, 32'(i + 1));
    mdDone = 1'b1;
    cyc("md_done", 3'b000, 3'b000, 2'b00, 2'b00, 1, 0, 5);
    mdDone = 1'b0;
    cyc("md_back_run", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 5);
    mdDone = 1'b1;
    cyc("md_done_stray", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 5);
    mdStart_E = 1'b1;
    cyc("md_single_cycle", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 5);
    clear_inputs();
    cyc("md_single_after", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 5);

    // Timeout: eight MD_WAIT cycles without mdDone
    mdStart_E = 1'b1;
    cyc("to_start", 3'b111, 3'b001, 2'b00, 2'b00, 0, 0, 5);
    clear_inputs();
    for (int i = 0; i < 7; i++)
      cyc("to_wait", 3'b111, 3'b001, 2'b00, 2'b00, 1, 0, 32'(i + 6));
    cyc("to_expire", 3'b000, 3'b000, 2'b00, 2'b00, 1, 0, 13);
    cyc("to_error", 3'b000, 3'b000, 2'b00, 2'b00, 0, 1, 13);
    memRead_E = 1'b1; writeReg_E = 5'd4; readRegister1_D = 5'd4;
    cyc("to_err_load_use", 3'b110, 3'b010, 2'b00, 2'b00, 0, 1, 13);
    clear_inputs();
    cyc("to_err_sticky", 3'b000, 3'b000, 2'b00, 2'b00, 0, 1, 14);

    // Reset while waiting on mul/div
    mdStart_E = 1'b1;
    cyc("rst_md_start", 3'b111, 3'b001, 2'b00, 2'b00, 0, 1, 14);
    clear_inputs();
    reset = 1'b1; pcSrc_E = 1'b1;
    cyc("rst_md_assert", 3'b000, 3'b000, 2'b00, 2'b00, 1, 1, 15);
    reset = 1'b0; clear_inputs();
    cyc("rst_md_after", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0);
    cyc("rst_md_idle", 3'b000, 3'b000, 2'b00, 2'b00, 0, 0, 0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
